fetch_unit: RTL

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of branch_control.
- Owns the PC and issues one-outstanding-request fetches to instruction memory. Presents instr/PC_4 to the decode stage, where branch_control consumes them.
- Takes take_branch/PC_branch back from branch_control as a redirect: flushes IF/ID and kills any in-flight fetch.

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle for fetch_unit
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // fetch side drives requests and receives read data
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // memory side accepts requests and returns read data
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, single-outstanding instruction fetch and IF/ID register
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         take_branch,
    input  logic [31:0]  PC_branch,
    fetch_unit_if.master imem,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_PC_4,
    output logic         if_valid
);

    // WAIT: request outstanding; HOLD: response parked in buffer during a stall;
    // DROP: request outstanding but its response must be discarded after a redirect
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_4_q, if_pc_4_d;
    logic        if_valid_q, if_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        load_en;
    logic [31:0] load_data;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = PC_branch & ~32'h3;

    // a redirect in FETCH suppresses the request so the old pc is never fetched
    assign imem.imem_req  = (state_q == FETCH) & ~take_branch & ~rst;
    assign imem.imem_addr = pc_q & ~32'h3;

    assign if_instr = if_instr_q;
    assign if_PC_4  = if_pc_4_q;
    assign if_valid = if_valid_q;

    // state register, PC, response buffer and IF/ID pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            buf_q      <= 32'h0;
            if_instr_q <= NOP_INSTR;
            if_pc_4_q  <= 32'h0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            if_instr_q <= if_instr_d;
            if_pc_4_q  <= if_pc_4_d;
            if_valid_q <= if_valid_d;
        end
    end

    // next-state, PC update and IF/ID load/bubble/hold selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        if_instr_d = if_instr_q;
        if_pc_4_d  = if_pc_4_q;
        if_valid_d = if_valid_q;
        load_en    = 1'b0;
        load_data  = NOP_INSTR;

        if (take_branch) begin
            // redirect wins over stall: flush IF/ID, keep if_PC_4, retarget pc
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            case (state_q)
                WAIT:    state_d = imem.imem_rvalid ? FETCH : DROP;
                DROP:    state_d = imem.imem_rvalid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    // a response here would be a protocol error and is ignored
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!stall) begin
                            load_en   = 1'b1;
                            load_data = imem.imem_rdata;
                            state_d   = FETCH;
                        end else begin
                            buf_d   = imem.imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        load_en   = 1'b1;
                        load_data = buf_q;
                        state_d   = FETCH;
                    end
                end
                DROP: begin
                    if (imem.imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase

            if (load_en) begin
                if_instr_d = load_data;
                if_pc_4_d  = pc_plus4;
                if_valid_d = 1'b1;
                pc_d       = pc_plus4;
            end else if (!stall) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        end
    end

endmodule
